// File: rtl/md_fp32_pkg.sv
// Shared fp32 field definitions and helpers for the pair-force pipeline
// (cutoff filter, fp32_sqrt_lut and the force stages behind them).
package md_fp32_pkg;

  localparam int         SIGN_BIT = 31;
  localparam int         EXP_MSB  = 30;
  localparam int         EXP_LSB  = 23;
  localparam logic [7:0] EXP_ALL1 = 8'hFF;

  // Tag width used by pipeline stages that carry the default packed index pair.
  localparam int PAIR_TAG_W = 16;

  // One candidate pair as it travels between stages.
  typedef struct packed {
    logic [31:0]           r2;
    logic [PAIR_TAG_W-1:0] tag;
  } pair_t;

  // True for +denormal, +normal; false for +/-0, any negative, inf and NaN.
  function automatic logic fp32_is_pos_finite_nonzero(input logic [31:0] v);
    return !v[SIGN_BIT] && (v[EXP_MSB:0] != '0) && (v[EXP_MSB:EXP_LSB] != EXP_ALL1);
  endfunction

  // True when v is a usable cutoff: non-negative and not NaN (+inf is allowed).
  function automatic logic fp32_is_valid_cutoff(input logic [31:0] v);
    return !v[SIGN_BIT] && !((v[EXP_MSB:EXP_LSB] == EXP_ALL1) && (v[EXP_LSB-1:0] != '0));
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO. The head entry is always visible
// on rdata; occupancy is tracked explicitly and full/empty derive from it.
module sync_fifo_fwft #(
  parameter  int WIDTH = 48,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Overflow/underflow and flush protection so callers may drive push/pop loosely.
  assign do_push = push && !clear && (level != LVL_W'(DEPTH));
  assign do_pop  = pop  && !clear && (level != '0);

  assign rdata = mem[rd_ptr];

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/r2_cutoff_filter.sv
// Cutoff-sphere filter ahead of the sqrt stage: drops pairs with r2 outside
// the cutoff, self-pairs and non-finite encodings, and queues survivors.
module r2_cutoff_filter
  import md_fp32_pkg::*;
#(
  parameter int TAG_W = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [31:0]            cfg_rc2,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_r2,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_r2,
  output logic [TAG_W-1:0]       out_tag,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       cnt_pass,
  output logic [CNT_W-1:0]       cnt_drop
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0]      r2;
    logic [TAG_W-1:0] tag;
  } rec_t;

  rec_t wr_rec;
  rec_t rd_rec;
  logic accept;
  logic r2_pass;
  logic push;
  logic drop;
  logic pop;

  // Statistics counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // For non-negative fp32 the 31-bit magnitude orders like an unsigned integer,
  // so a plain compare of bits [30:0] is a valid r2 < rc2 test.
  assign r2_pass = fp32_is_pos_finite_nonzero(in_r2) &&
                   fp32_is_valid_cutoff(cfg_rc2) &&
                   (in_r2[EXP_MSB:0] < cfg_rc2[EXP_MSB:0]);

  // No pop bypass: a full FIFO stalls upstream regardless of out_ready.
  assign in_ready  = rst_n && (fifo_level != LVL_W'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign push      = accept && r2_pass && !clear;
  assign drop      = accept && !r2_pass && !clear;
  assign out_valid = (fifo_level != '0);
  assign pop       = out_valid && out_ready;

  assign wr_rec.r2  = in_r2;
  assign wr_rec.tag = in_tag;

  // Head is don't-care when empty; present zeros so reset shows clean outputs.
  assign out_r2  = out_valid ? rd_rec.r2  : '0;
  assign out_tag = out_valid ? rd_rec.tag : '0;

  sync_fifo_fwft #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (wr_rec),
    .rdata (rd_rec),
    .level (fifo_level)
  );

  // Pass/drop statistics; a flush zeroes them and ignores that edge's accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_pass <= '0;
      cnt_drop <= '0;
    end else if (clear) begin
      cnt_pass <= '0;
      cnt_drop <= '0;
    end else begin
      if (push) cnt_pass <= sat_inc(cnt_pass);
      if (drop) cnt_drop <= sat_inc(cnt_drop);
    end
  end

endmodule

// File: tb/tb_r2_cutoff_filter.sv
// Directed bench for r2_cutoff_filter with hand-computed expectations.
module tb_r2_cutoff_filter;

  localparam int TAG_W = 16;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic [31:0]      cfg_rc2 = 32'h4110_0000;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_r2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_r2;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       fifo_level;
  logic [CNT_W-1:0] cnt_pass;
  logic [CNT_W-1:0] cnt_drop;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  r2_cutoff_filter #(.TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_rc2(cfg_rc2),
    .in_valid(in_valid), .in_ready(in_ready), .in_r2(in_r2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_r2(out_r2), .out_tag(out_tag),
    .fifo_level(fifo_level), .cnt_pass(cnt_pass), .cnt_drop(cnt_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_cmp++; if (cnt_pass !== 32'd0 || cnt_drop !== 32'd0) begin n_bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cnt_pass, cnt_drop); end
    n_cmp++; if (out_r2 !== 32'd0 || out_tag !== 16'd0) begin n_bad++; $display("FAIL reset_out_data: got %h/%h want 0/0", out_r2, out_tag); end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_cutoff();
    cfg_rc2 = 32'h4110_0000;
    out_ready = 1'b1;
    in_valid = 1'b1; in_r2 = 32'h4080_0000; in_tag = 16'd1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL cut_no_bypass: got %b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL cut_tag1_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_tag !== 16'd1 || out_r2 !== 32'h4080_0000) begin n_bad++; $display("FAIL cut_tag1_data: got %h/%h want 1/40800000", out_tag, out_r2); end
    in_r2 = 32'h4110_0000; in_tag = 16'd2;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL cut_equal_dropped: got %b want 0", out_valid); end
    in_r2 = 32'h4120_0000; in_tag = 16'd3;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL cut_above_dropped: got %b want 0", out_valid); end
    n_cmp++; if (cnt_pass !== 32'd1) begin n_bad++; $display("FAIL cut_cnt_pass: got %0d want 1", cnt_pass); end
    n_cmp++; if (cnt_drop !== 32'd2) begin n_bad++; $display("FAIL cut_cnt_drop: got %0d want 2", cnt_drop); end
    out_ready = 1'b0;
  endtask

  task automatic test_invalid();
    logic [31:0] v [5];
    v = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'hC000_0000};
    do_clear();
    cfg_rc2 = 32'h4110_0000;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_r2 = v[i]; in_tag = 16'(i + 10);
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL inv_dropped[%0d]: got %b want 0", i, out_valid); end
    end
    in_valid = 1'b0;
    n_cmp++; if (cnt_drop !== 32'd5) begin n_bad++; $display("FAIL inv_cnt_drop: got %0d want 5", cnt_drop); end
    n_cmp++; if (cnt_pass !== 32'd0) begin n_bad++; $display("FAIL inv_cnt_pass: got %0d want 0", cnt_pass); end
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    int next_tag;
    int npop;
    int cyc;
    int first_pop;
    int acc9;
    int got [10];
    do_clear();
    cfg_rc2 = 32'h4110_0000;
    out_ready = 1'b0;
    in_r2 = 32'h3F80_0000;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_tag = 16'(i);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
    end
    in_tag = 16'd9;
    n_cmp++; if (fifo_level !== 4'd8) begin n_bad++; $display("FAIL full_level: got %0d want 8", fifo_level); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_not_ready: got %b want 0", in_ready); end
    tick();
    n_cmp++; if (fifo_level !== 4'd8 || cnt_pass !== 32'd8) begin n_bad++; $display("FAIL full_hold: got level %0d pass %0d want 8/8", fifo_level, cnt_pass); end
    out_ready = 1'b1;
    next_tag = 9; npop = 0; cyc = 0; first_pop = -1; acc9 = -1;
    while (npop < 10 && cyc < 60) begin
      if (out_valid) begin
        got[npop] = int'(out_tag);
        npop++;
        if (first_pop < 0) first_pop = cyc;
      end
      if (in_valid && in_ready) begin
        if (next_tag == 9) acc9 = cyc;
        next_tag++;
      end
      tick();
      if (next_tag > 10) in_valid = 1'b0;
      else in_tag = 16'(next_tag);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (npop !== 10) begin n_bad++; $display("FAIL full_pop_count: got %0d want 10", npop); end
    for (int k = 0; k < npop; k++) begin
      n_cmp++; if (got[k] !== k + 1) begin n_bad++; $display("FAIL full_order[%0d]: got %0d want %0d", k, got[k], k + 1); end
    end
    n_cmp++; if (first_pop !== 0 || acc9 !== 1) begin n_bad++; $display("FAIL full_accept9_after_pop: got pop %0d acc9 %0d want 0/1", first_pop, acc9); end
  endtask

  task automatic test_steady();
    do_clear();
    cfg_rc2 = 32'h4110_0000;
    out_ready = 1'b0;
    in_r2 = 32'h3F80_0000;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_tag = 16'(i);
      tick();
    end
    n_cmp++; if (fifo_level !== 4'd3) begin n_bad++; $display("FAIL steady_prefill: got %0d want 3", fifo_level); end
    out_ready = 1'b1;
    in_tag = 16'd4;
    for (int c = 0; c < 20; c++) begin
      n_cmp++; if (out_tag !== 16'(c + 1)) begin n_bad++; $display("FAIL steady_tag[%0d]: got %0d want %0d", c, out_tag, c + 1); end
      n_cmp++; if (fifo_level !== 4'd3) begin n_bad++; $display("FAIL steady_level[%0d]: got %0d want 3", c, fifo_level); end
      tick();
      in_tag = 16'(c + 5);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    n_cmp++; if (fifo_level !== 4'd3 || out_tag !== 16'd21) begin n_bad++; $display("FAIL steady_end: got level %0d head %0d want 3/21", fifo_level, out_tag); end
  endtask

  task automatic test_special();
    do_clear();
    out_ready = 1'b0;
    cfg_rc2 = 32'h7F80_0000;
    in_valid = 1'b1; in_r2 = 32'h0000_0001; in_tag = 16'h0055;
    tick();
    n_cmp++; if (fifo_level !== 4'd1 || out_r2 !== 32'h0000_0001 || out_tag !== 16'h0055) begin n_bad++; $display("FAIL spec_denorm_inf: got level %0d head %h/%h want 1 00000001/0055", fifo_level, out_r2, out_tag); end
    in_r2 = 32'h7F7F_FFFF; in_tag = 16'h0056;
    tick();
    n_cmp++; if (fifo_level !== 4'd2 || cnt_pass !== 32'd2) begin n_bad++; $display("FAIL spec_maxfinite_inf: got level %0d pass %0d want 2/2", fifo_level, cnt_pass); end
    cfg_rc2 = 32'hBF80_0000;
    in_r2 = 32'h3F80_0000; in_tag = 16'h0057;
    tick();
    n_cmp++; if (fifo_level !== 4'd2 || cnt_drop !== 32'd1) begin n_bad++; $display("FAIL spec_neg_cutoff: got level %0d drop %0d want 2/1", fifo_level, cnt_drop); end
    cfg_rc2 = 32'h7FC0_0000;
    in_r2 = 32'h3F80_0000; in_tag = 16'h0058;
    tick();
    n_cmp++; if (fifo_level !== 4'd2 || cnt_drop !== 32'd2) begin n_bad++; $display("FAIL spec_nan_cutoff: got level %0d drop %0d want 2/2", fifo_level, cnt_drop); end
    cfg_rc2 = 32'h0080_0000;
    in_r2 = 32'h007F_FFFF; in_tag = 16'h0059;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (fifo_level !== 4'd3 || cnt_pass !== 32'd3) begin n_bad++; $display("FAIL spec_denorm_vs_minnorm: got level %0d pass %0d want 3/3", fifo_level, cnt_pass); end
  endtask

  task automatic test_clear_reset();
    do_clear();
    cfg_rc2 = 32'h4110_0000;
    out_ready = 1'b0;
    in_r2 = 32'h3F80_0000;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_tag = 16'(i);
      tick();
    end
    in_r2 = 32'h4120_0000; in_tag = 16'd5;
    tick();
    n_cmp++; if (fifo_level !== 4'd4 || cnt_pass !== 32'd4 || cnt_drop !== 32'd1) begin n_bad++; $display("FAIL clr_setup: got level %0d pass %0d drop %0d want 4/4/1", fifo_level, cnt_pass, cnt_drop); end
    in_r2 = 32'h3F80_0000; in_tag = 16'd99;
    out_ready = 1'b1;
    clear = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL clr_in_ready: got %b want 1", in_ready); end
    tick();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (fifo_level !== 4'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_flushed: got level %0d valid %b want 0/0", fifo_level, out_valid); end
    n_cmp++; if (cnt_pass !== 32'd0 || cnt_drop !== 32'd0) begin n_bad++; $display("FAIL clr_counters: got %0d/%0d want 0/0", cnt_pass, cnt_drop); end
    tick();
    n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL clr_not_stored: got %0d want 0", fifo_level); end
    in_valid = 1'b1; in_tag = 16'd7;
    tick();
    in_tag = 16'd8;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_tag !== 16'd7) begin n_bad++; $display("FAIL rst_setup: got valid %b head %0d want 1/7", out_valid, out_tag); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin n_bad++; $display("FAIL rst_async_out: got valid %b level %0d want 0/0", out_valid, fifo_level); end
    n_cmp++; if (in_ready !== 1'b0 || cnt_pass !== 32'd0 || out_r2 !== 32'd0) begin n_bad++; $display("FAIL rst_async_ctrl: got ready %b pass %0d r2 %h want 0/0/0", in_ready, cnt_pass, out_r2); end
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    test_reset();
    test_cutoff();
    test_invalid();
    test_full();
    test_steady();
    test_special();
    test_clear_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
